ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary of the LEGv8 5-stage core. It registers execute-stage results and control, and feeds the memory/writeback register directly (RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M, ALUResult_M, ReadData2_M, DestinationReg_M).
- Resolves CBZ/CBNZ/B in MEM and drives the PC-select and branch target to fetch.
- Supports stall, external flush and self-flush of the wrong-path instruction.
- Exports MEM-stage forwarding info to the hazard/forwarding unit.

Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register index width
- CNT_W, 32, performance counter width (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  hold all stage registers
- flush  in  1  replace incoming instruction with bubble
- Valid_E  in  1  EX stage holds a real instruction
- RegWrite_E, MemWrite_E, MemToReg_E, MemRead_E  in  1 each  EX control
- Branch_E  in  1  CBZ
- BranchNot_E  in  1  CBNZ
- UncondBranch_E  in  1  B
- Zero_E  in  1  ALU zero flag
- ALUResult_E  in  DATA_W  ALU result / memory address
- ReadData2_E  in  DATA_W  store data
- BranchTarget_E  in  DATA_W  PC + (imm<<2)
- DestinationReg_E  in  REG_W  Rd/Rt
- Valid_M  out  1  registered valid
- RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M  out  1 each  to MEM/WB
- ALUResult_M, ReadData2_M  out  DATA_W  to MEM/WB
- DestinationReg_M  out  REG_W  to MEM/WB
- PCSrc_M  out  1  branch taken, to fetch
- BranchTarget_M  out  DATA_W  redirect address
- FwdValid_M  out  1  forwarding candidate (combinational from registers)
- FwdReg_M  out  REG_W  = DestinationReg_M
- FwdData_M  out  DATA_W  = ALUResult_M

Behaviour:
- Reset (async, immediate): every output register = 0, including Valid_M, PCSrc_M and all controls. Combinational outputs therefore read 0.
- Latency: 1 cycle EX -> M.
- Priority at each rising edge: reset > kill > stall > load. kill = flush | PCSrc_M.
- kill:
  - Valid_M, RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M and PCSrc_M load 0.
  - Data fields (ALUResult_M, ReadData2_M, BranchTarget_M, DestinationReg_M) load EX values normally.
- stall (no kill): all registers hold their value, including PCSrc_M. Upstream owns the stall/redirect interlock.
- load:
  - Valid_M = Valid_E.
  - Each control output = control_E & Valid_E.
  - Data fields load EX values.
- XZR: if DestinationReg_E == 31 on load, RegWrite_M loads 0. MemRead_M is unaffected.
- Branch decision: taken_E = Valid_E & ((Branch_E & Zero_E) | (BranchNot_E & ~Zero_E) | UncondBranch_E). PCSrc_M loads taken_E.
- Self-flush: PCSrc_M is high for exactly one cycle after a taken branch. On the following edge the wrong-path EX instruction becomes a bubble, and PCSrc_M returns to 0.
- Simultaneous branch flags: any one true flag gives taken (OR semantics). Controls behave identically for branches: a branch carries RegWrite_E = 0 from decode, and no extra gating is applied here.
- FwdValid_M = Valid_M & RegWrite_M & (DestinationReg_M != 31).
- No arithmetic in block; widths pass through unchanged.

Optional Feature:
- Macro: EX_MEM_PERF_EN
- Defined: adds outputs TakenCnt_M [CNT_W] and BubbleCnt_M [CNT_W], both reset to 0.
  - TakenCnt_M increments on each edge where PCSrc_M loads 1.
  - BubbleCnt_M increments on each edge where Valid_M loads 0 (kill, or invalid input, not stall).
  - Both saturate at all-ones; stall does not count.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Assert reset mid-cycle with outputs non-zero -> all outputs 0 immediately, before the next edge; after release, first load occurs at the next edge.
- ADD (Valid_E=1, RegWrite_E=1, ALUResult_E=0x1234, Rd=5) -> next cycle RegWrite_M=1, ALUResult_M=0x1234, FwdValid_M=1, FwdReg_M=5.
- CBZ, Zero_E=1, BranchTarget_E=0x40 -> PCSrc_M=1, BranchTarget_M=0x40 for one cycle. Next EX instruction (a store) arrives with MemWrite_M=0 and Valid_M=0. PCSrc_M is 0 the cycle after.
- CBNZ with Zero_E=1 -> PCSrc_M=0; the following instruction passes with Valid_M=1.
- LDUR to X31 (MemRead_E=1, RegWrite_E=1, Rd=31) -> MemRead_M=1, RegWrite_M=0, FwdValid_M=0.
- Stall held 3 cycles while inputs change -> outputs frozen. flush and stall together -> bubble loaded. With EX_MEM_PERF_EN defined, BubbleCnt_M increments by exactly 1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register of the LEGv8 5-stage core.
// Registers execute results and control and resolves CBZ/CBNZ/B in MEM.
// When a taken branch reaches MEM it redirects fetch for one cycle and turns
// the wrong-path EX instruction into a bubble. It also exports MEM-stage
// forwarding information.
// Optional feature macro: EX_MEM_PERF_EN adds saturating counters for taken
// branches and bubbles (TakenCnt_M, BubbleCnt_M).
module ex_mem_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              Valid_E,
    input  logic              RegWrite_E,
    input  logic              MemWrite_E,
    input  logic              MemToReg_E,
    input  logic              MemRead_E,
    input  logic              Branch_E,
    input  logic              BranchNot_E,
    input  logic              UncondBranch_E,
    input  logic              Zero_E,
    input  logic [DATA_W-1:0] ALUResult_E,
    input  logic [DATA_W-1:0] ReadData2_E,
    input  logic [DATA_W-1:0] BranchTarget_E,
    input  logic [REG_W-1:0]  DestinationReg_E,
    output logic              Valid_M,
    output logic              RegWrite_M,
    output logic              MemWrite_M,
    output logic              MemToReg_M,
    output logic              MemRead_M,
    output logic [DATA_W-1:0] ALUResult_M,
    output logic [DATA_W-1:0] ReadData2_M,
    output logic [REG_W-1:0]  DestinationReg_M,
    output logic              PCSrc_M,
    output logic [DATA_W-1:0] BranchTarget_M,
    output logic              FwdValid_M,
    output logic [REG_W-1:0]  FwdReg_M,
`ifdef EX_MEM_PERF_EN
    output logic [CNT_W-1:0]  TakenCnt_M,
    output logic [CNT_W-1:0]  BubbleCnt_M,
`endif
    output logic [DATA_W-1:0] FwdData_M
);

    // X31 reads as zero, so writes to it are discarded.
    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memwrite_q, memwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              memread_q, memread_d;
    logic              pcsrc_q, pcsrc_d;
    logic [DATA_W-1:0] aluresult_q, aluresult_d;
    logic [DATA_W-1:0] readdata2_q, readdata2_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [REG_W-1:0]  dest_q, dest_d;

    logic kill_s;
    logic taken_s;

    assign kill_s  = flush | pcsrc_q;
    assign taken_s = Valid_E & ((Branch_E & Zero_E) | (BranchNot_E & ~Zero_E) | UncondBranch_E);

    // Next-state selection: kill beats stall, stall beats a normal load.
    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        memwrite_d  = memwrite_q;
        memtoreg_d  = memtoreg_q;
        memread_d   = memread_q;
        pcsrc_d     = pcsrc_q;
        aluresult_d = aluresult_q;
        readdata2_d = readdata2_q;
        target_d    = target_q;
        dest_d      = dest_q;
        if (kill_s) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            memwrite_d  = 1'b0;
            memtoreg_d  = 1'b0;
            memread_d   = 1'b0;
            pcsrc_d     = 1'b0;
            aluresult_d = ALUResult_E;
            readdata2_d = ReadData2_E;
            target_d    = BranchTarget_E;
            dest_d      = DestinationReg_E;
        end else if (stall) begin
            valid_d     = valid_q;
        end else begin
            valid_d     = Valid_E;
            regwrite_d  = RegWrite_E & Valid_E & (DestinationReg_E != XZR);
            memwrite_d  = MemWrite_E & Valid_E;
            memtoreg_d  = MemToReg_E & Valid_E;
            memread_d   = MemRead_E & Valid_E;
            pcsrc_d     = taken_s;
            aluresult_d = ALUResult_E;
            readdata2_d = ReadData2_E;
            target_d    = BranchTarget_E;
            dest_d      = DestinationReg_E;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            memread_q   <= 1'b0;
            pcsrc_q     <= 1'b0;
            aluresult_q <= {DATA_W{1'b0}};
            readdata2_q <= {DATA_W{1'b0}};
            target_q    <= {DATA_W{1'b0}};
            dest_q      <= {REG_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            memtoreg_q  <= memtoreg_d;
            memread_q   <= memread_d;
            pcsrc_q     <= pcsrc_d;
            aluresult_q <= aluresult_d;
            readdata2_q <= readdata2_d;
            target_q    <= target_d;
            dest_q      <= dest_d;
        end
    end

    assign Valid_M          = valid_q;
    assign RegWrite_M       = regwrite_q;
    assign MemWrite_M       = memwrite_q;
    assign MemToReg_M       = memtoreg_q;
    assign MemRead_M        = memread_q;
    assign PCSrc_M          = pcsrc_q;
    assign ALUResult_M      = aluresult_q;
    assign ReadData2_M      = readdata2_q;
    assign BranchTarget_M   = target_q;
    assign DestinationReg_M = dest_q;

    // Forwarding view is derived only from registered MEM-stage state.
    assign FwdValid_M = valid_q & regwrite_q & (dest_q != XZR);
    assign FwdReg_M   = dest_q;
    assign FwdData_M  = aluresult_q;

`ifdef EX_MEM_PERF_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             load_en_s;

    // Counting happens only on edges that actually update the stage.
    assign load_en_s = kill_s | ~stall;

    // Saturating event counters.
    always_comb begin
        taken_cnt_d  = taken_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (load_en_s && pcsrc_d && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            taken_cnt_d = taken_cnt_q;
        end
        if (load_en_s && !valid_d && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            taken_cnt_q  <= taken_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign TakenCnt_M  = taken_cnt_q;
    assign BubbleCnt_M = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the driver pushes the expected MEM-stage
// state for every edge, and the monitor pops and compares after each edge.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, flush = 1'b0;
    logic        Valid_E = 1'b0, RegWrite_E = 1'b0, MemWrite_E = 1'b0, MemToReg_E = 1'b0, MemRead_E = 1'b0;
    logic        Branch_E = 1'b0, BranchNot_E = 1'b0, UncondBranch_E = 1'b0, Zero_E = 1'b0;
    logic [63:0] ALUResult_E = 64'd0, ReadData2_E = 64'd0, BranchTarget_E = 64'd0;
    logic [4:0]  DestinationReg_E = 5'd0;
    logic        Valid_M, RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M, PCSrc_M, FwdValid_M;
    logic [63:0] ALUResult_M, ReadData2_M, BranchTarget_M, FwdData_M;
    logic [4:0]  DestinationReg_M, FwdReg_M;
`ifdef EX_MEM_PERF_EN
    logic [31:0] TakenCnt_M, BubbleCnt_M;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        v, rw, mw, mtr, mr, pc;
        logic [63:0] alu, rd2, tgt;
        logic [4:0]  dst;
        logic [31:0] tcnt, bcnt;
    } exp_t;

    exp_t m;
    exp_t q[$];

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .Valid_E(Valid_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E),
        .MemToReg_E(MemToReg_E), .MemRead_E(MemRead_E), .Branch_E(Branch_E),
        .BranchNot_E(BranchNot_E), .UncondBranch_E(UncondBranch_E), .Zero_E(Zero_E),
        .ALUResult_E(ALUResult_E), .ReadData2_E(ReadData2_E), .BranchTarget_E(BranchTarget_E),
        .DestinationReg_E(DestinationReg_E),
        .Valid_M(Valid_M), .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M),
        .MemToReg_M(MemToReg_M), .MemRead_M(MemRead_M), .ALUResult_M(ALUResult_M),
        .ReadData2_M(ReadData2_M), .DestinationReg_M(DestinationReg_M), .PCSrc_M(PCSrc_M),
        .BranchTarget_M(BranchTarget_M), .FwdValid_M(FwdValid_M), .FwdReg_M(FwdReg_M),
`ifdef EX_MEM_PERF_EN
        .TakenCnt_M(TakenCnt_M), .BubbleCnt_M(BubbleCnt_M),
`endif
        .FwdData_M(FwdData_M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one EX-stage instruction at the falling edge and records what
    // the MEM stage must show after the next rising edge.
    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic mw, input logic mtr, input logic mr, input logic b,
                         input logic bn, input logic u, input logic z, input logic [63:0] alu,
                         input logic [63:0] rd2, input logic [63:0] tgt, input logic [4:0] dst);
        exp_t n;
        logic taken;
        logic kill;
        @(negedge clk);
        stall = st; flush = fl; Valid_E = v; RegWrite_E = rw; MemWrite_E = mw;
        MemToReg_E = mtr; MemRead_E = mr; Branch_E = b; BranchNot_E = bn;
        UncondBranch_E = u; Zero_E = z; ALUResult_E = alu; ReadData2_E = rd2;
        BranchTarget_E = tgt; DestinationReg_E = dst;
        taken = v && ((b && z) || (bn && !z) || u);
        kill = fl || m.pc;
        n = m;
        if (kill || !st) begin
            n.alu = alu; n.rd2 = rd2; n.tgt = tgt; n.dst = dst;
            if (kill) begin
                n.v = 1'b0; n.rw = 1'b0; n.mw = 1'b0; n.mtr = 1'b0; n.mr = 1'b0; n.pc = 1'b0;
            end else begin
                n.v = v; n.rw = rw && v && (dst != 5'd31); n.mw = mw && v;
                n.mtr = mtr && v; n.mr = mr && v; n.pc = taken;
            end
            if (n.pc && n.tcnt != 32'hFFFF_FFFF) n.tcnt = n.tcnt + 32'd1;
            if (!n.v && n.bcnt != 32'hFFFF_FFFF) n.bcnt = n.bcnt + 32'd1;
        end
        m = n;
        q.push_back(n);
    endtask

    task automatic rand_instr();
        logic [4:0] d;
        d = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom);
        drive($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
              1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, d);
    endtask

    task automatic nop(input logic st, input logic fl);
        drive(st, fl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'd0, 64'd0, 64'd0, 5'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " valid"}, {63'd0, Valid_M}, 64'd0);
        chk({tag, " ctrl"}, {60'd0, RegWrite_M, MemWrite_M, MemToReg_M, MemRead_M}, 64'd0);
        chk({tag, " pcsrc"}, {63'd0, PCSrc_M}, 64'd0);
        chk({tag, " alu"}, ALUResult_M, 64'd0);
        chk({tag, " rd2"}, ReadData2_M, 64'd0);
        chk({tag, " tgt"}, BranchTarget_M, 64'd0);
        chk({tag, " dst"}, {59'd0, DestinationReg_M}, 64'd0);
        chk({tag, " fwd"}, {58'd0, FwdValid_M, FwdReg_M}, 64'd0);
        chk({tag, " fwddata"}, FwdData_M, 64'd0);
`ifdef EX_MEM_PERF_EN
        chk({tag, " cnts"}, {TakenCnt_M, BubbleCnt_M}, 64'd0);
`endif
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid", {63'd0, Valid_M}, {63'd0, e.v});
                chk("regwrite", {63'd0, RegWrite_M}, {63'd0, e.rw});
                chk("memwrite", {63'd0, MemWrite_M}, {63'd0, e.mw});
                chk("memtoreg", {63'd0, MemToReg_M}, {63'd0, e.mtr});
                chk("memread", {63'd0, MemRead_M}, {63'd0, e.mr});
                chk("pcsrc", {63'd0, PCSrc_M}, {63'd0, e.pc});
                chk("alu", ALUResult_M, e.alu);
                chk("rd2", ReadData2_M, e.rd2);
                chk("tgt", BranchTarget_M, e.tgt);
                chk("dst", {59'd0, DestinationReg_M}, {59'd0, e.dst});
                chk("fwdvalid", {63'd0, FwdValid_M}, {63'd0, e.v && e.rw && e.dst != 5'd31});
                chk("fwdreg", {59'd0, FwdReg_M}, {59'd0, e.dst});
                chk("fwddata", FwdData_M, e.alu);
`ifdef EX_MEM_PERF_EN
                chk("takencnt", {32'd0, TakenCnt_M}, {32'd0, e.tcnt});
                chk("bubblecnt", {32'd0, BubbleCnt_M}, {32'd0, e.bcnt});
`endif
            end
        end
    end

    initial begin
        m = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        // ADD X5 and forwarding
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h1234, 64'h99, 64'h0, 5'd5);
        // CBZ taken, then a wrong-path store, then a follower
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
              64'h0, 64'h0, 64'h40, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h100, 64'hABCD, 64'h0, 5'd7);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h5, 64'h0, 64'h0, 5'd3);
        // CBNZ with Zero=1 not taken; follower passes
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
              64'h0, 64'h0, 64'h80, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h77, 64'h0, 64'h0, 5'd9);
        // LDUR to X31
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h200, 64'h0, 64'h0, 5'd31);
        // stall three cycles with changing inputs, then stall+flush
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h55, 64'h66, 64'h77, 5'd4);
        // taken B while stalled next cycle: kill still wins
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
              64'h0, 64'h0, 64'h300, 5'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'h11, 64'h0, 64'h0, 5'd2);
        for (int i = 0; i < 150; i++) rand_instr();
        // mid-cycle reset with non-zero outputs
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
              64'hDEAD, 64'hBEEF, 64'hF00D, 5'd12);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        m = '0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              64'hCAFE, 64'h1, 64'h2, 5'd6);
        for (int i = 0; i < 150; i++) rand_instr();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
